instr_fetch_stage: RTL and testbench

//   IF stage directly downstream of program_counter. Issues word fetches for
//   pc_in to instruction memory over a valid/ready request channel with
//   in-order responses. Pulses pc_advance (wired to PC en) on each accepted

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch_stage.sv | 105 ++++++++++
 tb/tb_instr_fetch_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  localparam logic [DataWidth-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    logic                 epoch;
  } fetch_tag_t;

  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    logic [DataWidth-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; clear wins over push/pop, push on full is legal with a pop.
module fetch_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  T                data_i,
  input  logic            pop_i,
  output T                data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_en, pop_en;
  T                mem_q [Depth];

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign pop_en  = pop_i & ~empty_o & ~clear_i;
  assign push_en = push_i & ~clear_i & (~full_o | pop_en);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) wptr_d = wptr_q + PtrW'(1);
      if (pop_en)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i && !clear_i));

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: credit-limited fetch requests to imem, epoch-tagged in-order responses,
// buffered {pc, instr} pairs presented to ID.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] pc_i,
  output logic                 pc_advance_o,
  input  logic                 flush_i,
  output logic                 imem_req_valid_o,
  input  logic                 imem_req_ready_i,
  output logic [AddrWidth-1:0] imem_req_addr_o,
  input  logic                 imem_resp_valid_i,
  input  logic [DataWidth-1:0] imem_resp_data_i,
  output logic                 id_valid_o,
  input  logic                 id_ready_i,
  output logic [AddrWidth-1:0] id_pc_o,
  output logic [DataWidth-1:0] id_instr_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic            running_q, running_d;
  logic            epoch_q, epoch_d;
  logic [CntW-1:0] tag_count, out_count, used;
  logic            tag_full, tag_empty, out_full, out_empty;
  logic            accept, out_push, out_pop;
  fetch_tag_t      tag_in, tag_head;
  fetch_entry_t    out_in, out_head;

  // Tag entries cover in-flight fetches, including stale ones after a flush,
  // so credits only come back once their responses have drained.
  assign used             = tag_count + out_count;
  assign imem_req_valid_o = running_q & ~flush_i & (used < CntW'(Depth));
  assign imem_req_addr_o  = pc_i;
  assign accept           = imem_req_valid_o & imem_req_ready_i;
  assign pc_advance_o     = accept;

  assign tag_in   = '{pc: pc_i, epoch: epoch_q};
  assign out_in   = '{pc: tag_head.pc, instr: imem_resp_data_i};
  assign out_push = imem_resp_valid_i & (tag_head.epoch == epoch_q) & ~flush_i;
  assign out_pop  = id_valid_o & id_ready_i;

  assign id_valid_o = ~out_empty;
  assign id_pc_o    = out_head.pc;
  assign id_instr_o = out_empty ? NOP_INSTR : out_head.instr;

  fetch_fifo #(
    .T     (fetch_tag_t),
    .Depth (Depth)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .push_i  (accept),
    .data_i  (tag_in),
    .pop_i   (imem_resp_valid_i),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .Depth (Depth)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (out_push),
    .data_i  (out_in),
    .pop_i   (out_pop),
    .data_o  (out_head),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  always_comb begin
    running_d = 1'b1;
    epoch_d   = epoch_q ^ flush_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      running_q <= 1'b0;
      epoch_q   <= 1'b0;
    end else begin
      running_q <= running_d;
      epoch_q   <= epoch_d;
    end
  end

  unsolicited_resp_a: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_resp_valid_i |-> !tag_empty);
  inflight_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (tag_count <= CntW'(Depth)) && !(accept && tag_full));
  out_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(out_push && out_full && !out_pop));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, flush corner sequences, random run
// checked against a queue-based model of PC, memory and ID delivery.
module tb_instr_fetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr;

  always #5 clk = ~clk;

  instr_fetch_stage #(.Depth(DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pc_i              (pc_in),
    .pc_advance_o      (pc_advance),
    .flush_i           (flush),
    .imem_req_valid_o  (req_valid),
    .imem_req_ready_i  (req_ready),
    .imem_req_addr_o   (req_addr),
    .imem_resp_valid_i (resp_valid),
    .imem_resp_data_i  (resp_data),
    .id_valid_o        (id_valid),
    .id_ready_i        (id_ready),
    .id_pc_o           (id_pc),
    .id_instr_o        (id_instr)
  );

  typedef struct { logic [31:0] addr; int gen; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
  typedef struct {
    bit fl; bit rr; bit ir; logic [31:0] jump;
    bit e_rv; bit e_idv; logic [31:0] e_pc;
  } vec_t;

  pend_t       mem_q[$];
  item_t       exp_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, gen = 0, dmin = 0, dmax = 0, last_due = 0, dut_deliv = 0;
  bit          running_exp = 1'b0;
  logic [31:0] pc_model = '0;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit fl, input bit rr, input bit ir, input logic [31:0] jump,
                       output bit s_rv, output bit s_idv, output logic [31:0] s_pc);
    bit    exp_rv;
    int    due;
    pend_t p;
    item_t it;
    @(negedge clk);
    flush = fl; req_ready = rr; id_ready = ir; pc_in = pc_model;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      resp_valid = 1'b1; resp_data = img(mem_q[0].addr);
    end else begin
      resp_valid = 1'b0; resp_data = '0;
    end
    #1;
    s_rv = req_valid; s_idv = id_valid; s_pc = id_pc;
    if (id_valid && ir) dut_deliv++;
    exp_rv = running_exp && !fl && (mem_q.size() + exp_q.size() < DEPTH);
    chk("req_valid", req_valid, exp_rv);
    chk("pc_advance", pc_advance, exp_rv && rr);
    if (exp_rv) chk("req_addr", req_addr, pc_model);
    chk("id_valid", id_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("id_pc", id_pc, exp_q[0].pc);
      chk("id_instr", id_instr, exp_q[0].instr);
      if (ir) it = exp_q.pop_front();
    end
    if (fl) exp_q.delete();
    if (resp_valid) begin
      p = mem_q.pop_front();
      if (p.gen == gen && !fl) exp_q.push_back('{p.addr, img(p.addr)});
    end
    if (exp_rv && rr) begin
      due = cyc + 1 + int'($urandom_range(dmax, dmin));
      if (due < last_due) due = last_due;
      last_due = due;
      mem_q.push_back('{pc_model, gen, due});
      pc_model += 32'd4;
    end
    if (fl) begin
      gen++;
      pc_model = jump;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; req_ready = 1'b1; id_ready = 1'b1;
    resp_valid = 1'b0; resp_data = '0; pc_in = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_req_valid", req_valid, 0);
      chk("rst_pc_advance", pc_advance, 0);
      chk("rst_id_valid", id_valid, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("release_req_valid", req_valid, 0);
    mem_q.delete(); exp_q.delete();
    pc_model = '0; gen = 0; cyc = 0; last_due = 0; running_exp = 1'b1;
  endtask

  task automatic drain();
    bit rv, idv; logic [31:0] pcv;
    for (int i = 0; i < 40 && (mem_q.size() + exp_q.size()) != 0; i++)
      cycle(1'b0, 1'b0, 1'b1, '0, rv, idv, pcv);
  endtask

  vec_t vecs[13];

  initial begin
    bit          rv, idv, fl, found;
    logic [31:0] pcv, first_pc;

    rst = 1'b1; flush = 1'b0; req_ready = 1'b0; id_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; pc_in = '0;

    // Backpressure fill, ordered drain, then flush with a response in the same cycle.
    vecs[0]  = '{0, 1, 0, 32'h0,   1, 0, 32'h0};
    vecs[1]  = '{0, 1, 0, 32'h0,   1, 0, 32'h0};
    vecs[2]  = '{0, 1, 0, 32'h0,   1, 1, 32'h0};
    vecs[3]  = '{0, 1, 0, 32'h0,   1, 1, 32'h0};
    vecs[4]  = '{0, 1, 0, 32'h0,   0, 1, 32'h0};
    vecs[5]  = '{0, 1, 0, 32'h0,   0, 1, 32'h0};
    vecs[6]  = '{0, 1, 1, 32'h0,   0, 1, 32'h0};
    vecs[7]  = '{0, 1, 1, 32'h0,   1, 1, 32'h4};
    vecs[8]  = '{0, 1, 1, 32'h0,   1, 1, 32'h8};
    vecs[9]  = '{1, 1, 0, 32'h100, 0, 1, 32'hC};
    vecs[10] = '{0, 1, 0, 32'h0,   1, 0, 32'h0};
    vecs[11] = '{0, 1, 1, 32'h0,   1, 0, 32'h0};
    vecs[12] = '{0, 1, 1, 32'h0,   1, 1, 32'h100};

    do_reset();
    dmin = 0; dmax = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].fl, vecs[i].rr, vecs[i].ir, vecs[i].jump, rv, idv, pcv);
      chk($sformatf("vec%0d_req_valid", i), rv, vecs[i].e_rv);
      chk($sformatf("vec%0d_id_valid", i), idv, vecs[i].e_idv);
      if (vecs[i].e_idv) chk($sformatf("vec%0d_id_pc", i), pcv, vecs[i].e_pc);
    end

    // Flush with two fetches in flight on a slow memory.
    drain();
    dmin = 3; dmax = 3;
    cycle(1'b0, 1'b1, 1'b0, '0, rv, idv, pcv);
    chk("inflight_a_req", rv, 1);
    cycle(1'b0, 1'b1, 1'b0, '0, rv, idv, pcv);
    chk("inflight_b_req", rv, 1);
    cycle(1'b1, 1'b1, 1'b0, 32'h100, rv, idv, pcv);
    chk("flush_no_req", rv, 0);
    found = 1'b0; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 1'b1, 1'b1, '0, rv, idv, pcv);
      if (idv) begin found = 1'b1; first_pc = pcv; end
    end
    chk("post_flush_first_pc", first_pc, 32'h100);

    // Flush while the output buffer is full.
    drain();
    dmin = 0; dmax = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, '0, rv, idv, pcv);
    chk("full_req_blocked", rv, 0);
    chk("full_id_valid", idv, 1);
    cycle(1'b1, 1'b1, 1'b0, 32'h200, rv, idv, pcv);
    cycle(1'b0, 1'b1, 1'b0, '0, rv, idv, pcv);
    chk("full_flush_id_valid", idv, 0);
    chk("full_flush_credits", rv, 1);

    // Random traffic with a mid-run reset.
    dmin = 0; dmax = 4;
    dut_deliv = 0;
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) begin
        do_reset();
      end
      fl = 1'b1;
      foreach (mem_q[k]) if (mem_q[k].gen != gen) fl = 1'b0;
      fl = fl && ($urandom_range(39, 0) == 0);
      cycle(fl, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
            32'($urandom_range(255, 0)) << 2, rv, idv, pcv);
    end
    chk("random_progress", dut_deliv > 500, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
